// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux among four requesters.
// Each grant is held for a burst that ends on the source's last beat or after MAX_BURST beats.
module rr_mux4_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          req,
   input  logic [4*DATA_W-1:0] din,
   input  logic [3:0]          last,
   output logic [3:0]          ack,
   output logic [1:0]          sel,
   output logic                busy,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   input  logic                out_ready
);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       handshake;
   logic       found;
   logic [1:0] cand;

   // Datapath and handshake are purely combinational off the registered select.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ack       = '0;
      busy      = (state_q == ST_BUSY);
      out_valid = busy & req[sel_q];
      out_data  = din[int'(sel_q)*DATA_W +: DATA_W];
      out_last  = out_valid & last[sel_q];
      handshake = out_valid & out_ready;
      ack[sel_q] = handshake;
   end

   // First requester at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      found = 1'b0;
      cand  = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         if (!found && req[rr_ptr_q + 2'(k)]) begin
            found = 1'b1;
            cand  = rr_ptr_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               sel_d      = cand;
               beat_cnt_d = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (handshake) begin
               if (last[sel_q] || (beat_cnt_q == LAST_BEAT)) begin
                  state_d    = ST_IDLE;
                  rr_ptr_d   = sel_q + 2'd1;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign sel = sel_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed scenarios plus random traffic, scored against
// a grant/burst reference model through expected-status and expected-beat queues.
module tb_rr_mux4_arbiter;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [3:0]          req;
   logic [4*DATA_W-1:0] din;
   logic [3:0]          last;
   logic [3:0]          ack;
   logic [1:0]          sel;
   logic                busy;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic                out_last;
   logic                out_ready;

   rr_mux4_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din       (din),
      .last      (last),
      .ack       (ack),
      .sel       (sel),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              busy;
      logic [1:0]        sel;
      logic              valid;
      logic              olast;
      logic [3:0]        ack;
      logic [DATA_W-1:0] data;
   } status_t;

   typedef struct {
      int                src;
      logic [DATA_W-1:0] data;
      logic              lst;
   } beat_t;

   status_t status_q[$];
   beat_t   beat_q[$];
   int      errors = 0;
   int      checks = 0;

   // Reference model: which requester owns the mux (-1 = none), where the next
   // search starts, and how many beats the current owner has delivered.
   int         m_grant = -1;
   int         m_start = 0;
   int         m_beats = 0;
   int         m_sel   = 0;
   logic [3:0] m_ack   = '0;

   logic [3:0]          g_req  = '0;
   logic [3:0]          g_last = '0;
   logic [4*DATA_W-1:0] g_din  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] rq, input logic [4*DATA_W-1:0] d,
                        input logic [3:0] l, input logic rdy);
      status_t s;
      beat_t   b;
      logic    v;
      @(negedge clk);
      rst       = r;
      req       = rq;
      din       = d;
      last      = l;
      out_ready = rdy;
      s.busy  = (m_grant >= 0);
      s.sel   = 2'(m_sel);
      s.valid = 1'b0;
      s.olast = 1'b0;
      s.ack   = '0;
      s.data  = '0;
      if (m_grant >= 0) begin
         v       = rq[m_grant];
         s.valid = v;
         s.data  = d[m_grant*DATA_W +: DATA_W];
         s.olast = v & l[m_grant];
         if (v && rdy) begin
            s.ack  = 4'b0001 << m_grant;
            b.src  = m_grant;
            b.data = s.data;
            b.lst  = l[m_grant];
            beat_q.push_back(b);
         end
      end
      status_q.push_back(s);
      m_ack = s.ack;
      if (r) begin
         m_grant = -1;
         m_start = 0;
         m_beats = 0;
         m_sel   = 0;
      end else if (m_grant < 0) begin
         for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_start + k) % 4;
            if (rq[c]) begin
               m_grant = c;
               m_sel   = c;
               m_beats = 0;
               break;
            end
         end
      end else if (s.ack != 0) begin
         m_beats++;
         if (l[m_grant] || m_beats == MAX_BURST) begin
            m_start = (m_grant + 1) % 4;
            m_grant = -1;
            m_beats = 0;
         end
      end
   endtask

   // Random requesters obey the rule: hold data/last while requesting and not yet acked.
   task automatic rand_cycle(input logic r);
      for (int i = 0; i < 4; i++) begin
         if (!g_req[i]) begin
            if ($urandom_range(1, 0) == 1) begin
               g_req[i]                    = 1'b1;
               g_din[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               g_last[i]                   = ($urandom_range(3, 0) == 0);
            end
         end else if (m_ack[i]) begin
            if ($urandom_range(9, 0) < 7) begin
               g_din[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               g_last[i]                   = ($urandom_range(3, 0) == 0);
            end else begin
               g_req[i] = 1'b0;
            end
         end else if ($urandom_range(19, 0) == 0) begin
            g_req[i] = 1'b0;
         end
      end
      drive(r, g_req, g_din, g_last, $urandom_range(3, 0) != 0);
   endtask

   // Monitor: compares every cycle's status and pops a beat on each DUT handshake.
   initial begin
      status_t s;
      beat_t   b;
      forever begin
         @(negedge clk);
         #2;
         if (status_q.size() > 0) begin
            s = status_q.pop_front();
            check("busy", busy, s.busy);
            check("sel", sel, s.sel);
            check("out_valid", out_valid, s.valid);
            check("out_last", out_last, s.olast);
            check("ack", ack, s.ack);
            if (s.valid) check("out_data", out_data, s.data);
            if (out_valid && out_ready) begin
               if (beat_q.size() == 0) begin
                  check("beat_unexpected", 1, 0);
               end else begin
                  b = beat_q.pop_front();
                  check("beat_src", ack, 4'b0001 << b.src);
                  check("beat_data", out_data, b.data);
                  check("beat_last", out_last, b.lst);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; req = '0; din = '0; last = '0; out_ready = 1'b0;

      // Reset, then idle.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 4'b0000, '0, 4'b0000, 1'b1);
         #3;
         check("t1_busy", busy, 0);
         check("t1_valid", out_valid, 0);
         check("t1_ack", ack, 0);
         check("t1_sel", sel, 0);
      end

      // Single-beat packet from requester 2.
      drive(1'b0, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1);
      #3; check("t2_bubble", busy, 0);
      drive(1'b0, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1);
      #3;
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, 8'hA5);
      check("t2_last", out_last, 1);
      check("t2_ack", ack, 4'b0100);
      check("t2_sel", sel, 2);
      drive(1'b0, 4'b1001, 32'h3300_0011, 4'b1001, 1'b1);
      #3; check("t2_idle", busy, 0);
      drive(1'b0, 4'b1001, 32'h3300_0011, 4'b1001, 1'b1);
      #3; check("t2_rr_ptr3", sel, 3);

      // All four requesting, no last: forced rotation 0,1,2,3,0.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      for (int c = 0; c < 25; c++) begin
         drive(1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 1'b1);
         #3;
         if (c % 5 == 0) check("t3_bubble", busy, 0);
         else check("t3_last", out_last, 0);
         if (c % 5 == 1) check("t3_order", sel, (c / 5) % 4);
      end

      // Downstream stall mid-burst on requester 1.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      drive(1'b0, 4'b0010, 32'h0000_5A00, 4'b0000, 1'b1);
      drive(1'b0, 4'b0010, 32'h0000_5A00, 4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 4'b0010, 32'h0000_5B00, 4'b0000, 1'b0);
         #3;
         check("t4_valid", out_valid, 1);
         check("t4_ack", ack, 0);
         check("t4_sel", sel, 1);
      end
      for (int c = 0; c < 3; c++) drive(1'b0, 4'b0010, 32'h0000_5B00, 4'b0000, 1'b1);
      drive(1'b0, 4'b0000, '0, 4'b0000, 1'b1);
      #3; check("t4_release", busy, 0);

      // Requester 3 bubbles while requester 0 waits.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      drive(1'b0, 4'b1000, 32'hC300_0000, 4'b0000, 1'b1);
      drive(1'b0, 4'b1000, 32'hC300_0000, 4'b0000, 1'b1);
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 4'b0001, 32'h0000_00C0, 4'b0000, 1'b1);
         #3;
         check("t5_sel", sel, 3);
         check("t5_valid", out_valid, 0);
         check("t5_ack", ack, 0);
      end
      drive(1'b0, 4'b1001, 32'hC400_00C0, 4'b0000, 1'b1);
      #3; check("t5_resume", ack, 4'b1000);
      for (int c = 0; c < 8; c++) drive(1'b0, 4'b1001, 32'hC500_00C0, 4'b0000, 1'b1);

      // Reset mid-burst on requester 2.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) drive(1'b0, 4'b0100, 32'h0077_0000, 4'b0000, 1'b1);
      drive(1'b1, 4'b0100, 32'h0077_0000, 4'b0000, 1'b0);
      drive(1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 1'b1);
      #3;
      check("t6_idle", busy, 0);
      check("t6_sel", sel, 0);
      drive(1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 1'b1);
      #3;
      check("t6_grant0", sel, 0);
      check("t6_busy", busy, 1);

      // Random traffic with occasional resets.
      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      g_req = '0;
      m_ack = '0;
      for (int c = 0; c < 3000; c++) rand_cycle($urandom_range(299, 0) == 0);

      drive(1'b1, 4'b0000, '0, 4'b0000, 1'b1);
      drive(1'b0, 4'b0000, '0, 4'b0000, 1'b1);
      #3;
      check("beats_outstanding", beat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
